// File: rtl/transmissor_paridade.sv
// Serial transmitter for a 5-bit word with odd parity.
// Frame on tx: start(0), E[0]..E[4] LSB first, parity, stop(1).
// Every bit lasts BAUD_DIV clocks, timed by a down-counter.
module transmissor_paridade #(
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] E,
    input  logic       valido,
    output logic       pronto,
    output logic       tx,
    output logic       ocupado,
    output logic       paridade
);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_t;

    // Counter reload: the counter counts down to zero, so a bit spans BAUD_DIV edges.
    localparam logic [7:0] RECARGA = 8'(BAUD_DIV - 1);

    estado_t    estado;
    logic [7:0] cnt;
    logic [2:0] bitidx;
    logic [4:0] shreg;

    // Frame sequencer; every output is registered so tx cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= OCIOSO;
            cnt      <= '0;
            bitidx   <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            pronto   <= 1'b1;
            ocupado  <= 1'b0;
            paridade <= 1'b0;
        end else if (estado == OCIOSO) begin
            // pronto is high whenever we sit here, so valido alone accepts.
            if (valido) begin
                estado   <= INICIO;
                cnt      <= RECARGA;
                shreg    <= E;
                paridade <= ~^E;
                tx       <= 1'b0;
                pronto   <= 1'b0;
                ocupado  <= 1'b1;
            end
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end else begin
            // Bit boundary: reload the counter and drive the next bit.
            cnt <= RECARGA;
            case (estado)
                INICIO: begin
                    estado <= DADOS;
                    bitidx <= 3'd0;
                    tx     <= shreg[0];
                    shreg  <= {1'b0, shreg[4:1]};
                end
                DADOS: begin
                    if (bitidx == 3'd4) begin
                        estado <= PARIDADE;
                        tx     <= paridade;
                    end else begin
                        bitidx <= bitidx + 3'd1;
                        tx     <= shreg[0];
                        shreg  <= {1'b0, shreg[4:1]};
                    end
                end
                PARIDADE: begin
                    estado <= PARADA;
                    tx     <= 1'b1;
                end
                default: begin
                    // PARADA finished: back to idle, line stays high.
                    estado  <= OCIOSO;
                    cnt     <= '0;
                    tx      <= 1'b1;
                    pronto  <= 1'b1;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/transmissor_paridade.md
TRANSMISSOR_PARIDADE -- requirements
Module: transmissor_paridade

Interface
REQ-001 Parameter BAUD_DIV, default 4, SHALL set the clock cycles per serial bit period (legal range 1..255).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port E  input  5  SHALL carry the data word E1-E5 (E[0]=E1) to transmit.
REQ-005 Port valido  input  1  SHALL request transmission of E.
REQ-006 Port pronto  output  1  SHALL indicate the block can accept a word (registered).
REQ-007 Port tx  output  1  SHALL be the serial line output, idle high (registered).
REQ-008 Port ocupado  output  1  SHALL be high while a frame is on the line (registered).
REQ-009 Port paridade  output  1  SHALL hold the odd-parity bit of the last accepted word (registered).

Function
REQ-010 A word SHALL be accepted on a rising edge where valido=1 and pronto=1; valido while pronto=0 SHALL be ignored, not queued.
REQ-011 On acceptance, E SHALL be captured into an internal shift register; later changes of E SHALL not affect the frame.
REQ-012 On acceptance, paridade SHALL be set to ~^E, so that ^E ^ paridade = 1 (odd parity over 6 bits).
REQ-013 The frame SHALL be: start bit 0, E[0]..E[4] LSB first, paridade, stop bit 1, for 8 bits total.
REQ-014 Each bit SHALL hold on tx for exactly BAUD_DIV cycles, timed by an internal down-counter reloaded at each bit boundary.
REQ-015 The FSM SHALL have states OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
REQ-016 OCIOSO->INICIO on acceptance.
REQ-017 INICIO->DADOS after BAUD_DIV cycles.
REQ-018 DADOS->PARIDADE after 5 bit periods, tracked by a 3-bit bit index.
REQ-019 PARIDADE->PARADA after BAUD_DIV cycles.
REQ-020 PARADA->OCIOSO after BAUD_DIV cycles.
REQ-021 If acceptance occurs at edge k, tx SHALL be 0 from edge k, and the stop bit SHALL occupy edges k+7*BAUD_DIV..k+8*BAUD_DIV-1.
REQ-022 At edge k+8*BAUD_DIV, state SHALL return to OCIOSO with pronto=1, ocupado=0 and tx=1.
REQ-023 The earliest next acceptance SHALL be edge k+8*BAUD_DIV+1, giving a minimum 1-cycle idle-high gap between back-to-back frames.
REQ-024 pronto SHALL be 1 only in OCIOSO; ocupado SHALL be its complement.
REQ-025 tx SHALL be 1 in OCIOSO and PARADA and SHALL never glitch within a bit period.
REQ-026 With BAUD_DIV=1, each bit SHALL last one cycle and the frame SHALL take 8 cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force tx=1, pronto=1, ocupado=0, paridade=0, state OCIOSO, and clear the counters and shift register, including mid-frame.
REQ-028 After rst_n deasserts, the first rising edge with valido=1 SHALL be accepted normally; a truncated frame SHALL not resume.

Verification
REQ-029 BAUD_DIV=4, E=5'b10110, one-cycle valido pulse -> paridade=0; tx sequence 0,0,1,1,0,1,0,1 at 4 cycles each; pronto=1 after 32 cycles.
REQ-030 E=5'b00000 -> paridade=1, tx 0,0,0,0,0,0,1,1. E=5'b11111 -> paridade=0, tx 0,1,1,1,1,1,0,1.
REQ-031 valido held high, E changed mid-frame -> frames are sent back-to-back with exactly a 1-cycle tx=1 gap, and each frame carries the E captured at its own acceptance.
REQ-032 valido pulsed while ocupado=1 -> the pulse is ignored, with no extra frame.
REQ-033 rst_n asserted during the DADOS state -> tx=1 and pronto=1 asynchronously, before the next clock edge; a new word sent after release is correct.
REQ-034 Exhaustive check of all 32 E values with BAUD_DIV=1 -> each received frame passes an odd-parity check over the 5 data bits plus parity (XOR of the 6 bits = 1).
